// File: rtl/operand_entry_pkg.sv
// Shared types for the operand entry front end: FSM states and default operand width.
package operand_entry_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StOffer
  } state_e;

endpackage

// File: rtl/operand_entry_if.sv
// Operand pair handshake towards the adder datapath.
interface operand_entry_if
  import operand_entry_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
);

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_valid;
  logic              op_ready;

  modport master (
    output op_a,
    output op_b,
    output op_valid,
    input  op_ready
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  op_valid,
    output op_ready
  );

endinterface

// File: rtl/operand_entry_button_conditioner.sv
// Synchronise and debounce one active-low push-button; emit a 1-cycle pulse per press.
module operand_entry_button_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   stable_prev_q;
  logic                   press_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (synced != stable_q) begin
      // Accept the new level only after it has disagreed for DEBOUNCE_CYCLES counts.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
        stable_d = synced;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '1;
      cnt_q         <= '0;
      stable_q      <= 1'b1;
      stable_prev_q <= 1'b1;
      press_q       <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], button};
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      press_q       <= stable_prev_q & ~stable_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// Button-driven operand capture: loads A/B from switches and offers the pair to the adder.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned DATA_W          = DefaultDataW,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button0,
  input  logic              button1,
  input  logic              button2,
  input  logic [DATA_W-1:0] switch1,
  operand_entry_if.master   bus,
  output logic              a_loaded,
  output logic              b_loaded,
  output logic              overrun,
  output logic [7:0]        xfer_cnt
);

  logic press_clr, press_a, press_b;

  operand_entry_button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button0),
    .press  (press_clr)
  );

  operand_entry_button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button1),
    .press  (press_a)
  );

  operand_entry_button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button2),
    .press  (press_b)
  );

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              a_loaded_q, a_loaded_d;
  logic              b_loaded_q, b_loaded_d;
  logic              op_valid_q, op_valid_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        xfer_cnt_q, xfer_cnt_d;
  logic              xfer;

  assign xfer = op_valid_q & bus.op_ready;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    a_loaded_d = a_loaded_q;
    b_loaded_d = b_loaded_q;
    op_valid_d = op_valid_q;
    overrun_d  = overrun_q;
    xfer_cnt_d = xfer_cnt_q;

    unique case (state_q)
      StIdle, StCollect: begin
        if (press_a) begin
          op_a_d     = switch1;
          a_loaded_d = 1'b1;
        end
        if (press_b) begin
          op_b_d     = switch1;
          b_loaded_d = 1'b1;
        end
        if (a_loaded_d && b_loaded_d) begin
          state_d    = StOffer;
          op_valid_d = 1'b1;
        end else if (a_loaded_d || b_loaded_d) begin
          state_d = StCollect;
        end
      end
      StOffer: begin
        // Operands are frozen while offered; a load attempt only flags the overrun.
        if (press_a || press_b) begin
          overrun_d = 1'b1;
        end
        if (xfer) begin
          xfer_cnt_d = xfer_cnt_q + 8'd1;
          a_loaded_d = 1'b0;
          b_loaded_d = 1'b0;
          op_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear wins over everything except the transfer count already taken above.
    if (press_clr) begin
      op_a_d     = '0;
      op_b_d     = '0;
      a_loaded_d = 1'b0;
      b_loaded_d = 1'b0;
      op_valid_d = 1'b0;
      overrun_d  = 1'b0;
      state_d    = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_a_q     <= '0;
      op_b_q     <= '0;
      a_loaded_q <= 1'b0;
      b_loaded_q <= 1'b0;
      op_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      xfer_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      a_loaded_q <= a_loaded_d;
      b_loaded_q <= b_loaded_d;
      op_valid_q <= op_valid_d;
      overrun_q  <= overrun_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.op_valid = op_valid_q;
  assign a_loaded     = a_loaded_q;
  assign b_loaded     = b_loaded_q;
  assign overrun      = overrun_q;
  assign xfer_cnt     = xfer_cnt_q;

endmodule
